// File: rtl/paddle_key_sched_if.sv
// Keyboard byte stream in, paddle coordinates and key state out.
// The DUT uses the slave modport; the driver/monitor side uses master.
interface paddle_key_sched_if;
    logic [7:0] key_code;
    logic       key_valid;
    logic       frame_tick;
    logic [9:0] p1_x;
    logic [9:0] p1_y;
    logic [9:0] p2_x;
    logic [9:0] p2_y;
    logic       pos_valid;
    logic [7:0] held;
    logic       paused;

    modport master (
        output key_code, key_valid, frame_tick,
        input  p1_x, p1_y, p2_x, p2_y, pos_valid, held, paused
    );

    modport slave (
        input  key_code, key_valid, frame_tick,
        output p1_x, p1_y, p2_x, p2_y, pos_valid, held, paused
    );
endinterface

// File: rtl/paddle_key_sched.sv
// PS/2 scan-code decoder driving a two-player paddle position scheduler.
// Key state is tracked as a held bitmap; positions step once per frame tick.
module paddle_key_sched #(
    parameter int STEP  = 4,
    parameter int P1_X0 = 80,
    parameter int P1_Y0 = 240,
    parameter int P2_X0 = 560,
    parameter int P2_Y0 = 240
) (
    input  logic               clk,
    input  logic               reset,
    paddle_key_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_SPACE = 8'h29;

    localparam logic signed [10:0] P1_XMIN = 11'sd16;
    localparam logic signed [10:0] P1_XMAX = 11'sd303;
    localparam logic signed [10:0] P2_XMIN = 11'sd336;
    localparam logic signed [10:0] P2_XMAX = 11'sd623;
    localparam logic signed [10:0] Y_MIN   = 11'sd16;
    localparam logic signed [10:0] Y_MAX   = 11'sd463;

    state_t     state_q, state_d;
    logic [7:0] held_q, held_d;
    logic       space_q, space_d;
    logic       paused_q, paused_d;
    logic       pos_valid_q, pos_valid_d;
    logic [9:0] p1x_q, p1x_d, p1y_q, p1y_d, p2x_q, p2x_d, p2y_q, p2y_d;

    // One-hot {right,left,down,up} for a player's four direction keys.
    function automatic logic [3:0] base_map(input logic [7:0] code);
        case (code)
            8'h1D:   base_map = 4'b0001;
            8'h1B:   base_map = 4'b0010;
            8'h1C:   base_map = 4'b0100;
            8'h23:   base_map = 4'b1000;
            default: base_map = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] ext_map(input logic [7:0] code);
        case (code)
            8'h75:   ext_map = 4'b0001;
            8'h72:   ext_map = 4'b0010;
            8'h6B:   ext_map = 4'b0100;
            8'h74:   ext_map = 4'b1000;
            default: ext_map = 4'b0000;
        endcase
    endfunction

    // Opposing keys cancel; widened to signed so edge steps cannot wrap.
    function automatic logic signed [10:0] step_axis(input logic [9:0] pos,
                                                     input logic dec, input logic inc);
        logic signed [10:0] p;
        p = signed'({1'b0, pos});
        if (dec && !inc)
            p = p - 11'(STEP);
        else if (inc && !dec)
            p = p + 11'(STEP);
        return p;
    endfunction

    function automatic logic [9:0] sat_axis(input logic signed [10:0] v,
                                            input logic signed [10:0] lo,
                                            input logic signed [10:0] hi);
        logic signed [10:0] r;
        if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        else
            r = v;
        return r[9:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        space_d  = space_q;
        paused_d = paused_q;
        if (bus.key_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.key_code == CODE_EXT) begin
                        state_d = EXT;
                    end else if (bus.key_code == CODE_BRK) begin
                        state_d = BRK;
                    end else begin
                        held_d[3:0] = held_q[3:0] | base_map(bus.key_code);
                        if (bus.key_code == CODE_SPACE) begin
                            // Typematic repeats of a held space must not re-toggle.
                            if (!space_q)
                                paused_d = !paused_q;
                            space_d = 1'b1;
                        end
                    end
                end
                EXT: begin
                    if (bus.key_code == CODE_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        held_d[7:4] = held_q[7:4] | ext_map(bus.key_code);
                        state_d     = IDLE;
                    end
                end
                BRK: begin
                    held_d[3:0] = held_q[3:0] & ~base_map(bus.key_code);
                    if (bus.key_code == CODE_SPACE)
                        space_d = 1'b0;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    held_d[7:4] = held_q[7:4] & ~ext_map(bus.key_code);
                    state_d     = IDLE;
                end
            endcase
        end
    end

    // Motion reads held_q, so a byte landing on a tick affects the next frame.
    always_comb begin
        p1x_d       = p1x_q;
        p1y_d       = p1y_q;
        p2x_d       = p2x_q;
        p2y_d       = p2y_q;
        pos_valid_d = bus.frame_tick && !paused_q;
        if (pos_valid_d) begin
            p1y_d = sat_axis(step_axis(p1y_q, held_q[0], held_q[1]), Y_MIN, Y_MAX);
            p1x_d = sat_axis(step_axis(p1x_q, held_q[2], held_q[3]), P1_XMIN, P1_XMAX);
            p2y_d = sat_axis(step_axis(p2y_q, held_q[4], held_q[5]), Y_MIN, Y_MAX);
            p2x_d = sat_axis(step_axis(p2x_q, held_q[6], held_q[7]), P2_XMIN, P2_XMAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            held_q      <= 8'h00;
            space_q     <= 1'b0;
            paused_q    <= 1'b0;
            pos_valid_q <= 1'b0;
            p1x_q       <= 10'(P1_X0);
            p1y_q       <= 10'(P1_Y0);
            p2x_q       <= 10'(P2_X0);
            p2y_q       <= 10'(P2_Y0);
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            space_q     <= space_d;
            paused_q    <= paused_d;
            pos_valid_q <= pos_valid_d;
            p1x_q       <= p1x_d;
            p1y_q       <= p1y_d;
            p2x_q       <= p2x_d;
            p2y_q       <= p2y_d;
        end
    end

    assign bus.p1_x      = p1x_q;
    assign bus.p1_y      = p1y_q;
    assign bus.p2_x      = p2x_q;
    assign bus.p2_y      = p2y_q;
    assign bus.pos_valid = pos_valid_q;
    assign bus.held      = held_q;
    assign bus.paused    = paused_q;

endmodule

// File: tb/tb_paddle_key_sched.sv
// Bench for paddle_key_sched: directed scenarios plus a randomized byte/tick
// stream compared against a keyboard/paddle model built from plain integers.
module tb_paddle_key_sched;

    localparam int STEP = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    paddle_key_sched_if bus();

    paddle_key_sched #(
        .STEP(STEP), .P1_X0(80), .P1_Y0(240), .P2_X0(560), .P2_Y0(240)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int         m_px[2];
    int         m_py[2];
    logic [7:0] m_held;
    bit         m_space, m_paused, m_pv, m_ext, m_brk;

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int key_index(bit ext, logic [7:0] b);
        if (!ext) begin
            if (b == 8'h1D) return 0;
            if (b == 8'h1B) return 1;
            if (b == 8'h1C) return 2;
            if (b == 8'h23) return 3;
        end else begin
            if (b == 8'h75) return 4;
            if (b == 8'h72) return 5;
            if (b == 8'h6B) return 6;
            if (b == 8'h74) return 7;
        end
        return -1;
    endfunction

    function automatic void model_edge(bit rn, bit kv, logic [7:0] b, bit ft);
        int idx, dx, dy;
        if (!rn) begin
            m_px[0] = 80;  m_py[0] = 240;
            m_px[1] = 560; m_py[1] = 240;
            m_held = 8'h00; m_space = 0; m_paused = 0; m_pv = 0;
            m_ext = 0; m_brk = 0;
            return;
        end
        m_pv = ft && !m_paused;
        if (m_pv) begin
            for (int p = 0; p < 2; p++) begin
                dy = int'(m_held[4*p+1]) - int'(m_held[4*p+0]);
                dx = int'(m_held[4*p+3]) - int'(m_held[4*p+2]);
                m_py[p] = clamp(m_py[p] + STEP*dy, 16, 463);
                m_px[p] = clamp(m_px[p] + STEP*dx, (p == 0) ? 16 : 336, (p == 0) ? 303 : 623);
            end
        end
        if (kv) begin
            if (!m_brk && !m_ext && b == 8'hE0) begin
                m_ext = 1;
            end else if (!m_brk && b == 8'hF0) begin
                m_brk = 1;
            end else begin
                idx = key_index(m_ext, b);
                if (idx >= 0) m_held[idx] = !m_brk;
                if (!m_ext && b == 8'h29) begin
                    if (!m_brk) begin
                        if (!m_space) m_paused = !m_paused;
                        m_space = 1;
                    end else begin
                        m_space = 0;
                    end
                end
                m_ext = 0;
                m_brk = 0;
            end
        end
    endfunction

    // Called at a negedge; returns at the following negedge with inputs idle.
    task automatic do_cycle(bit rn, bit kv, logic [7:0] b, bit ft);
        reset          = rn;
        bus.key_valid  = kv;
        bus.key_code   = b;
        bus.frame_tick = ft;
        @(posedge clk);
        model_edge(rn, kv, b, ft);
        @(negedge clk);
        reset          = 1'b1;
        bus.key_valid  = 1'b0;
        bus.key_code   = 8'h00;
        bus.frame_tick = 1'b0;
    endtask

    task automatic send(logic [7:0] b);
        do_cycle(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic tick();
        do_cycle(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        do_cycle(1'b0, 1'b1, 8'h1D, 1'b1);
        checks += 7;
        if (bus.p1_x !== 10'd80)  begin errors++; $display("FAIL reset_p1_x: got %0d want 80", bus.p1_x); end
        if (bus.p1_y !== 10'd240) begin errors++; $display("FAIL reset_p1_y: got %0d want 240", bus.p1_y); end
        if (bus.p2_x !== 10'd560) begin errors++; $display("FAIL reset_p2_x: got %0d want 560", bus.p2_x); end
        if (bus.p2_y !== 10'd240) begin errors++; $display("FAIL reset_p2_y: got %0d want 240", bus.p2_y); end
        if (bus.held !== 8'h00)   begin errors++; $display("FAIL reset_held: got %h want 00", bus.held); end
        if (bus.paused !== 1'b0)  begin errors++; $display("FAIL reset_paused: got %b want 0", bus.paused); end
        if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL reset_pos_valid: got %b want 0", bus.pos_valid); end
    endtask

    task automatic test_single_key();
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h1D);
        checks++;
        if (bus.held !== 8'h01) begin errors++; $display("FAIL up_make_held: got %h want 01", bus.held); end
        tick();
        checks += 2;
        if (bus.p1_y !== 10'd236) begin errors++; $display("FAIL up_move_p1_y: got %0d want 236", bus.p1_y); end
        if (bus.pos_valid !== 1'b1) begin errors++; $display("FAIL up_move_pos_valid: got %b want 1", bus.pos_valid); end
        send(8'hF0);
        checks++;
        if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL pos_valid_one_cycle: got %b want 0", bus.pos_valid); end
        send(8'h1D);
        checks++;
        if (bus.held !== 8'h00) begin errors++; $display("FAIL up_break_held: got %h want 00", bus.held); end
    endtask

    task automatic test_saturate();
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send(8'hE0);
        send(8'h74);
        checks++;
        if (bus.held !== 8'h80) begin errors++; $display("FAIL p2_right_held: got %h want 80", bus.held); end
        for (int i = 0; i < 200; i++) tick();
        checks += 2;
        if (bus.p2_x !== 10'd623) begin errors++; $display("FAIL p2_x_saturate: got %0d want 623", bus.p2_x); end
        if (bus.p2_y !== 10'd240) begin errors++; $display("FAIL p2_y_still: got %0d want 240", bus.p2_y); end
    endtask

    task automatic test_opposing();
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h1D);
        send(8'h1B);
        tick();
        checks += 3;
        if (bus.held !== 8'h03)     begin errors++; $display("FAIL opposing_held: got %h want 03", bus.held); end
        if (bus.p1_y !== 10'd240)   begin errors++; $display("FAIL opposing_p1_y: got %0d want 240", bus.p1_y); end
        if (bus.pos_valid !== 1'b1) begin errors++; $display("FAIL opposing_pos_valid: got %b want 1", bus.pos_valid); end
    endtask

    task automatic test_pause();
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h1C);
        send(8'h29);
        checks++;
        if (bus.paused !== 1'b1) begin errors++; $display("FAIL pause_first: got %b want 1", bus.paused); end
        send(8'h29);
        send(8'h29);
        checks++;
        if (bus.paused !== 1'b1) begin errors++; $display("FAIL pause_typematic: got %b want 1", bus.paused); end
        tick();
        checks += 2;
        if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL paused_pos_valid: got %b want 0", bus.pos_valid); end
        if (bus.p1_x !== 10'd80)    begin errors++; $display("FAIL paused_p1_x: got %0d want 80", bus.p1_x); end
        send(8'hF0);
        send(8'h29);
        checks++;
        if (bus.paused !== 1'b1) begin errors++; $display("FAIL pause_after_break: got %b want 1", bus.paused); end
        send(8'h29);
        checks++;
        if (bus.paused !== 1'b0) begin errors++; $display("FAIL unpause: got %b want 0", bus.paused); end
        tick();
        checks += 2;
        if (bus.pos_valid !== 1'b1) begin errors++; $display("FAIL unpaused_pos_valid: got %b want 1", bus.pos_valid); end
        if (bus.p1_x !== 10'd76)    begin errors++; $display("FAIL unpaused_p1_x: got %0d want 76", bus.p1_x); end
    endtask

    task automatic test_reset_midseq();
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send(8'hE0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h75);
        checks++;
        if (bus.held !== 8'h00) begin errors++; $display("FAIL midseq_reset_held: got %h want 00", bus.held); end
        send(8'h1D);
        checks++;
        if (bus.held !== 8'h01) begin errors++; $display("FAIL midseq_then_base: got %h want 01", bus.held); end
    endtask

    task automatic test_same_cycle();
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        do_cycle(1'b1, 1'b1, 8'h1C, 1'b1);
        checks += 3;
        if (bus.p1_x !== 10'd80)    begin errors++; $display("FAIL same_cycle_p1_x: got %0d want 80", bus.p1_x); end
        if (bus.pos_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_pos_valid: got %b want 1", bus.pos_valid); end
        if (bus.held !== 8'h04)     begin errors++; $display("FAIL same_cycle_held: got %h want 04", bus.held); end
        tick();
        checks++;
        if (bus.p1_x !== 10'd76) begin errors++; $display("FAIL next_tick_p1_x: got %0d want 76", bus.p1_x); end
    endtask

    task automatic test_random();
        logic [7:0] pool[12];
        logic [7:0] b;
        bit kv, ft, rn;
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            b = pool[$urandom_range(0, 11)];
            if (b == 8'h00) b = 8'($urandom);
            kv = ($urandom_range(0, 1) == 1);
            ft = ($urandom_range(0, 2) == 0);
            rn = ($urandom_range(0, 199) != 0);
            do_cycle(rn, kv, b, ft);
            checks += 7;
            if (bus.p1_x !== 10'(m_px[0])) begin errors++; $display("FAIL rand_p1_x cyc %0d: got %0d want %0d", i, bus.p1_x, m_px[0]); end
            if (bus.p1_y !== 10'(m_py[0])) begin errors++; $display("FAIL rand_p1_y cyc %0d: got %0d want %0d", i, bus.p1_y, m_py[0]); end
            if (bus.p2_x !== 10'(m_px[1])) begin errors++; $display("FAIL rand_p2_x cyc %0d: got %0d want %0d", i, bus.p2_x, m_px[1]); end
            if (bus.p2_y !== 10'(m_py[1])) begin errors++; $display("FAIL rand_p2_y cyc %0d: got %0d want %0d", i, bus.p2_y, m_py[1]); end
            if (bus.held !== m_held)       begin errors++; $display("FAIL rand_held cyc %0d: got %h want %h", i, bus.held, m_held); end
            if (bus.paused !== m_paused)   begin errors++; $display("FAIL rand_paused cyc %0d: got %b want %b", i, bus.paused, m_paused); end
            if (bus.pos_valid !== m_pv)    begin errors++; $display("FAIL rand_pos_valid cyc %0d: got %b want %b", i, bus.pos_valid, m_pv); end
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 8'h00;
        bus.frame_tick = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_key();
        test_saturate();
        test_opposing();
        test_pause();
        test_reset_midseq();
        test_same_cycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paddle_key_sched.md
PADDLE_KEY_SCHED -- requirements
Module: paddle_key_sched

Interface
REQ-001 Parameter STEP, default 4, paddle displacement in pixels per frame tick (legal range 1..15).
REQ-002 Parameter P1_X0, default 80, player-1 reset x; P1_Y0, default 240, player-1 reset y.
REQ-003 Parameter P2_X0, default 560, player-2 reset x; P2_Y0, default 240, player-2 reset y.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 key_code  in  8  PS/2 scan-code byte from the keyboard receiver.
REQ-007 key_valid  in  1  one-cycle strobe: key_code holds a new byte.
REQ-008 frame_tick  in  1  one-cycle strobe, once per video frame.
REQ-009 p1_x, p1_y, p2_x, p2_y  out  10 each  paddle centre coordinates, registered.
REQ-010 pos_valid  out  1  one-cycle strobe: coordinates were updated this frame.
REQ-011 held  out  8  registered key-held bitmap {P2 R,L,D,U, P1 R,L,D,U}, bit0 = P1 up.
REQ-012 paused  out  1  registered pause state.

Function
REQ-013 Decoder FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); advances only on key_valid.
REQ-014 IDLE: byte E0 -> EXT; F0 -> BRK; any other byte is a base make code -> IDLE.
REQ-015 EXT: F0 -> EXT_BRK; any other byte is an extended make code -> IDLE.
REQ-016 BRK: any byte is a base break code -> IDLE; EXT_BRK: any byte is an extended break code -> IDLE.
REQ-017 Base map: 1D = P1 up, 1B = P1 down, 1C = P1 left, 23 = P1 right, 29 = space (pause).
REQ-018 Extended map: 75 = P2 up, 72 = P2 down, 6B = P2 left, 74 = P2 right.
REQ-019 A make sets the mapped held bit; a break clears it; unmapped codes change no state beyond the FSM.
REQ-020 Space make toggles paused only if space was not already held (typematic repeats ignored); space break clears the space-held flag.
REQ-021 Held-bitmap and paused updates take effect on the clock edge that accepts the final byte of the sequence.
REQ-022 On frame_tick with paused = 0, each axis of each player moves by STEP: up = y - STEP, down = y + STEP, left = x - STEP, right = x + STEP.
REQ-023 Both opposing keys of one axis held -> no motion on that axis.
REQ-024 Results saturate to the bounds rather than wrapping: P1 x in [16,303], P2 x in [336,623], both y in [16,463].
REQ-025 Position arithmetic uses 11-bit signed intermediates; no underflow or overflow is observable on outputs.
REQ-026 Positions register one cycle after frame_tick; pos_valid pulses in that same cycle, including when no key is held.
REQ-027 frame_tick with paused = 1 -> positions hold and pos_valid stays 0.
REQ-028 key_valid and frame_tick in the same cycle -> the motion update uses the held bitmap as it was before that cycle's byte.
REQ-029 Both players are computed in parallel each tick; there is no priority between them.

Reset
REQ-030 reset = 0 at a clk edge -> FSM in IDLE, held = 00, space-held flag = 0, paused = 0, pos_valid = 0.
REQ-031 The same reset edge -> p1 = (P1_X0,P1_Y0), p2 = (P2_X0,P2_Y0).
REQ-032 Reset mid-sequence (e.g. after E0) discards the partial sequence; the next byte is decoded from IDLE.
REQ-033 Reset dominates key_valid and frame_tick in the same cycle.

Verification
REQ-034 Bytes 1D, then frame_tick -> held = 01; next cycle p1_y = 236 and pos_valid = 1; then F0 1D -> held = 00.
REQ-035 Bytes E0 74, then 200 ticks -> p2_x saturates at 623 and stays there; p2_y stays 240.
REQ-036 1D and 1B both held, tick -> p1_y unchanged and pos_valid = 1.
REQ-037 Bytes 29 29 29, then F0 29, then 29 -> paused = 1 after the first 29 and 0 after the last; ticks while paused give no pos_valid.
REQ-038 Bytes E0, then reset pulse, then 75 -> treated as an unmapped base make; held = 00.
REQ-039 key_valid (1C) and frame_tick in the same cycle -> p1_x unchanged that tick; the next tick gives p1_x = 76.
